// File: rtl/joy_serial_rx.sv
// Arcade joystick shift-chain reader.
// Generates JOY_LOAD / JOY_CLK for an external parallel-in/serial-out chain,
// deserialises JOY_DATA into shadow registers and commits both 12-bit
// active-low joystick words together once per 26-slot frame.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | after reset, waiting for the first JOY_CLK rising edge
// LOAD   | slot 0, JOY_LOAD low so the chain captures its inputs
// SETTLE | slot 1, chain output settling, nothing sampled
// SHIFT  | slots 2..25, one bit sampled per slot on the JOY_CLK fall

module joy_serial_rx #(
    parameter int CLK_DIV     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        JOY_DATA,
    output logic        JOY_CLK,
    output logic        JOY_LOAD,
    output logic [11:0] joystick1,
    output logic [11:0] joystick2,
    output logic        frame_strobe
);

    localparam int              DIV_W     = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [4:0]      SLOT_LAST = 5'd25;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        SHIFT  = 2'd3
    } state_t;

    state_t                 state;
    logic [DIV_W-1:0]       div_cnt;
    logic                   div_warm;
    logic                   div_tc;
    logic                   rise_tick;
    logic                   fall_tick;
    logic [4:0]             slot;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   data_s;
    logic [11:0]            shadow1;
    logic [11:0]            shadow2;

    // Synchroniser chain on the asynchronous serial input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], JOY_DATA};
        end
    end

    assign data_s = sync_q[SYNC_STAGES-1];

    // Half-period divider; the first terminal count after reset is swallowed
    // so JOY_CLK spends a full low phase before its first rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt  <= '0;
            div_warm <= 1'b0;
            JOY_CLK  <= 1'b0;
        end else if (div_tc) begin
            div_cnt  <= '0;
            div_warm <= 1'b1;
            if (div_warm) begin
                JOY_CLK <= ~JOY_CLK;
            end
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign div_tc    = (div_cnt == DIV_LAST);
    assign rise_tick = div_tc & div_warm & ~JOY_CLK;
    assign fall_tick = div_tc & div_warm &  JOY_CLK;

    // Frame sequencer: slot counter, load strobe, bit capture and commit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            slot         <= 5'd0;
            JOY_LOAD     <= 1'b1;
            shadow1      <= 12'hFFF;
            shadow2      <= 12'hFFF;
            joystick1    <= 12'hFFF;
            joystick2    <= 12'hFFF;
            frame_strobe <= 1'b0;
        end else begin
            frame_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise_tick) begin
                        state    <= LOAD;
                        slot     <= 5'd0;
                        JOY_LOAD <= 1'b0;
                    end
                end
                LOAD: begin
                    if (rise_tick) begin
                        state    <= SETTLE;
                        slot     <= 5'd1;
                        JOY_LOAD <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (rise_tick) begin
                        state <= SHIFT;
                        slot  <= 5'd2;
                    end
                end
                SHIFT: begin
                    if (rise_tick) begin
                        if (slot == SLOT_LAST) begin
                            // Commit and the next load pulse share this edge
                            joystick1    <= shadow1;
                            joystick2    <= shadow2;
                            frame_strobe <= 1'b1;
                            state        <= LOAD;
                            slot         <= 5'd0;
                            JOY_LOAD     <= 1'b0;
                        end else begin
                            slot <= slot + 5'd1;
                        end
                    end else if (fall_tick) begin
                        case (slot)
                            5'd2:    shadow1[8]  <= data_s;
                            5'd3:    shadow1[6]  <= data_s;
                            5'd4:    shadow1[5]  <= data_s;
                            5'd5:    shadow1[4]  <= data_s;
                            5'd6:    shadow1[3]  <= data_s;
                            5'd7:    shadow1[2]  <= data_s;
                            5'd8:    shadow1[1]  <= data_s;
                            5'd9:    shadow1[0]  <= data_s;
                            5'd10:   shadow2[8]  <= data_s;
                            5'd11:   shadow2[6]  <= data_s;
                            5'd12:   shadow2[5]  <= data_s;
                            5'd13:   shadow2[4]  <= data_s;
                            5'd14:   shadow2[3]  <= data_s;
                            5'd15:   shadow2[2]  <= data_s;
                            5'd16:   shadow2[1]  <= data_s;
                            5'd17:   shadow2[0]  <= data_s;
                            5'd18:   shadow2[10] <= data_s;
                            5'd19:   shadow2[11] <= data_s;
                            5'd20:   shadow2[9]  <= data_s;
                            5'd21:   shadow2[7]  <= data_s;
                            5'd22:   shadow1[10] <= data_s;
                            5'd23:   shadow1[11] <= data_s;
                            5'd24:   shadow1[9]  <= data_s;
                            5'd25:   shadow1[7]  <= data_s;
                            default: ;
                        endcase
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
